gray_conv_arbiter: RTL



---
 rtl/gray_conv_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv_arbiter
// Description : Round-robin arbiter sharing one BCD-to-Gray converter among
//               NREQ requesters, with a single-entry output register and
//               saturating conversion/error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_conv_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [4*NREQ-1:0]       req_bcd,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [3:0]              out_gray,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic                    out_err,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        conv_count,
    output logic [CNT_W-1:0]        err_count
);

    localparam int                c_ID_W    = $clog2(NREQ);
    localparam logic [c_ID_W-1:0] c_LAST    = c_ID_W'(NREQ - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [c_ID_W-1:0] r_ptr;
    logic [c_ID_W-1:0] r_id;
    logic [c_ID_W-1:0] w_gid;
    logic [NREQ-1:0]   w_onehot;
    logic              w_found;
    logic              w_can_accept;
    logic              w_xfer;
    logic [3:0]        w_bcd;
    logic              w_bcd_err;
    logic [3:0]        w_gray;
    logic [3:0]        r_gray;
    logic              r_err;
    logic [CNT_W-1:0]  r_conv;
    logic [CNT_W-1:0]  r_errc;

    // Requester i sits at search offset k from the pointer when ptr == (i-k) mod NREQ;
    // scanning k outward picks the first valid requester at or after ptr.
    always_comb begin
        w_found  = 1'b0;
        w_onehot = '0;
        w_gid    = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && req_valid[i] &&
                    (r_ptr == c_ID_W'((i - k + NREQ) % NREQ))) begin
                    w_found     = 1'b1;
                    w_onehot[i] = 1'b1;
                    w_gid       = c_ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_bcd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_onehot[i]) begin
                w_bcd = req_bcd[4*i +: 4];
            end
        end
    end

    assign w_bcd_err = (w_bcd > 4'd9);
    assign w_gray    = w_bcd_err ? 4'b0000
                                 : {w_bcd[3], w_bcd[3] ^ w_bcd[2],
                                    w_bcd[2] ^ w_bcd[1], w_bcd[1] ^ w_bcd[0]};

    assign w_xfer    = w_found && w_can_accept;
    assign req_ready = w_xfer ? w_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_EMPTY: if (w_xfer)                 w_state_nxt = c_FULL;
            c_FULL:  if (out_ready && !w_xfer)   w_state_nxt = c_EMPTY;
            default:                             w_state_nxt = c_EMPTY;
        endcase
    end

    always_comb begin
        out_valid    = (r_state == c_FULL);
        w_can_accept = (r_state == c_EMPTY) || out_ready;
    end

    // Result, pointer and counters only move on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gray <= '0;
            r_id   <= '0;
            r_err  <= 1'b0;
            r_ptr  <= '0;
            r_conv <= '0;
            r_errc <= '0;
        end else if (w_xfer) begin
            r_gray <= w_gray;
            r_id   <= w_gid;
            r_err  <= w_bcd_err;
            r_ptr  <= (w_gid == c_LAST) ? '0 : w_gid + c_ID_W'(1);
            if (w_bcd_err) begin
                if (r_errc != c_CNT_MAX) r_errc <= r_errc + CNT_W'(1);
            end else begin
                if (r_conv != c_CNT_MAX) r_conv <= r_conv + CNT_W'(1);
            end
        end
    end

    assign out_gray   = r_gray;
    assign out_id     = r_id;
    assign out_err    = r_err;
    assign conv_count = r_conv;
    assign err_count  = r_errc;

endmodule
`default_nettype wire
